// File: rtl/video_tile_unpack.sv
// Tile read unpacker: bursts 256-bit beats from DDR into a small beat FIFO and serves one RGB565 pixel per i_pix_req (1-cycle latency).
// Requests a burst only when the FIFO can take it whole; `TILE_UNDERFLOW_HOLD_EN` repeats the last pixel on underflow instead of black.
module video_tile_unpack #(
  parameter logic [3:0] IMAGE_TAG   = 4'd1,
  parameter int         DQ_WIDTH    = 32,
  parameter int         TILE_WIDTH  = 320,
  parameter int         TILE_HEIGHT = 180,
  parameter int         BURST_WORDS = 2,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         ADDR_WIDTH  = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_vs_in,
  input  logic                    i_pix_req,
  output logic [15:0]             o_pix_out,
  output logic                    o_pix_valid,
  output logic                    o_underflow,
  output logic                    o_burst_req,
  output logic [ADDR_WIDTH-1:0]   o_burst_addr,
  input  logic                    i_burst_ack,
  input  logic [DQ_WIDTH*8-1:0]   i_ddr_data,
  input  logic                    i_ddr_valid,
  input  logic [3:0]              i_ddr_id,
  output logic                    o_frame_done
);

  localparam int BEAT_W       = DQ_WIDTH * 8;
  localparam int PIX_PER_BEAT = BEAT_W / 16;
  localparam int IDX_W        = $clog2(PIX_PER_BEAT);
  localparam int FRAME_BEATS  = TILE_WIDTH * TILE_HEIGHT / 16;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = $clog2(BURST_WORDS + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_BEATS - BURST_WORDS);
  localparam logic [PTR_W:0]        DEPTH     = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]        BW_SLOTS  = (PTR_W + 1)'(BURST_WORDS);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(PIX_PER_BEAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_vs_d;
  logic [BEAT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [ADDR_WIDTH-1:0] r_burst_addr;
  logic [IDX_W-1:0]      r_pix_idx;
  logic [15:0]           r_pix_out;
  logic                  r_pix_valid;
  logic                  r_underflow;
  logic                  r_frame_done;
  logic                  w_burst_req;

  wire w_vs_rise     = i_vs_in & ~r_vs_d;
  wire w_vs_fall     = ~i_vs_in & r_vs_d;
  wire w_accept      = i_ddr_valid && (i_ddr_id == IMAGE_TAG);
  wire w_burst_end   = w_accept && (r_beat_cnt == CNT_W'(BURST_WORDS - 1));
  wire w_last_burst  = (r_burst_addr == LAST_ADDR);
  wire w_empty       = (r_count == '0);
  wire w_full        = (r_count == DEPTH);
  wire w_room        = ((DEPTH - r_count) >= BW_SLOTS);
  wire w_frame_start = (r_state == S_IDLE) && w_vs_fall;
  wire w_push        = (r_state == S_RECV) && w_accept && !w_full;
  wire w_pop         = i_pix_req && !w_empty && (r_pix_idx == IDX_LAST);

  always_comb begin
    w_next      = r_state;
    w_burst_req = 1'b0;
    case (r_state)
      S_IDLE:  if (w_vs_fall) w_next = S_REQ;
      S_REQ: begin
        w_burst_req = 1'b1;
        if (w_vs_rise)        w_next = S_IDLE;
        else if (i_burst_ack) w_next = S_RECV;
      end
      // A burst that completes on the vsync-rise cycle needs no draining.
      S_RECV: begin
        if (w_burst_end)    w_next = w_vs_rise ? S_IDLE : (w_last_burst ? S_DONE : S_WAIT);
        else if (w_vs_rise) w_next = S_DRAIN;
      end
      S_WAIT: begin
        if (w_vs_rise)   w_next = S_IDLE;
        else if (w_room) w_next = S_REQ;
      end
      S_DONE:  if (w_vs_rise) w_next = S_IDLE;
      S_DRAIN: if (w_burst_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_ddr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_vs_d       <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beat_cnt   <= '0;
      r_burst_addr <= '0;
      r_pix_idx    <= '0;
      r_pix_out    <= '0;
      r_pix_valid  <= 1'b0;
      r_underflow  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_vs_d       <= i_vs_in;
      r_frame_done <= (r_state == S_RECV) && w_burst_end && w_last_burst;
      r_pix_valid  <= i_pix_req;

      if (r_state == S_REQ && i_burst_ack)
        r_beat_cnt <= '0;
      else if ((r_state == S_RECV || r_state == S_DRAIN) && w_accept)
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);

      if (w_frame_start)
        r_burst_addr <= '0;
      else if (r_state == S_RECV && w_burst_end)
        r_burst_addr <= r_burst_addr + ADDR_WIDTH'(BURST_WORDS);

      if (w_frame_start) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
      end

      if (w_frame_start) begin
        r_pix_idx   <= '0;
        r_pix_out   <= '0;
        r_underflow <= 1'b0;
      end else if (i_pix_req) begin
        if (w_empty) begin
          r_underflow <= 1'b1;
`ifdef TILE_UNDERFLOW_HOLD_EN
          r_pix_out   <= r_pix_out;
`else
          r_pix_out   <= 16'h0000;
`endif
        end else begin
          r_pix_out <= r_mem[r_rd_ptr][16*r_pix_idx +: 16];
          r_pix_idx <= r_pix_idx + IDX_W'(1);
        end
      end
    end
  end

  assign o_pix_out    = r_pix_out;
  assign o_pix_valid  = r_pix_valid;
  assign o_underflow  = r_underflow;
  assign o_burst_req  = w_burst_req;
  assign o_burst_addr = r_burst_addr;
  assign o_frame_done = r_frame_done;

endmodule
